// File: rtl/d5m_frame_writer_if.sv
// Avalon-MM write-master bus between the frame writer and the SDRAM slave.
interface d5m_frame_writer_if #(
   parameter int unsigned ADDR_W = 32
) ();
   logic [ADDR_W-1:0] avm_address;
   logic              avm_write;
   logic [31:0]       avm_writedata;
   logic [3:0]        avm_byteenable;
   logic              avm_waitrequest;

   modport master (
      output avm_address, avm_write, avm_writedata, avm_byteenable,
      input  avm_waitrequest
   );

   modport slave (
      input  avm_address, avm_write, avm_writedata, avm_byteenable,
      output avm_waitrequest
   );
endinterface

// File: rtl/d5m_frame_writer.sv
// Packs the D5M 8-bit pixel stream into 32-bit words and writes each frame to a
// ping-pong SDRAM buffer through an Avalon-MM write master.
module d5m_frame_writer #(
   parameter int unsigned COLS       = 800,
   parameter int unsigned LINES      = 480,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned ADDR_W     = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              clear_status,
   input  logic [ADDR_W-1:0] base_addr0,
   input  logic [ADDR_W-1:0] base_addr1,
   input  logic [7:0]        data_in,
   input  logic              data_valid,
   input  logic              startofpacket,
   input  logic              endofpacket,
   d5m_frame_writer_if.master avm,
   output logic              frame_done,
   output logic              cur_buf,
   output logic              overflow,
   output logic              frame_error
);
   localparam int unsigned N     = COLS * LINES;
   localparam int unsigned CNT_W = ($clog2(N + 1) < 2) ? 2 : $clog2(N + 1);
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_FLUSH, S_DONE} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] off;
      logic [3:0]        be;
      logic [31:0]       data;
   } entry_t;

   state_t            state;
   logic [CNT_W-1:0]  pix_cnt;
   logic [CNT_W-1:0]  word_idx;
   logic [31:0]       pack_data;
   logic [3:0]        pack_be;
   logic              push_vld;
   entry_t            push_ent;
   logic [ADDR_W-1:0] wbase;
   logic              frm_err;
   logic              frm_ovf;

   // The avm output registers act as the FIFO head slot; mem holds the rest.
   entry_t            mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [OCC_W-1:0]  mem_cnt;

   logic              start_c, acc_c, restart_c, last_c, len_bad_c, word_full_c, err_set_c;
   logic [CNT_W-1:0]  idx_c, wrd_c, cnt_new_c;
   logic [1:0]        lane_c;
   logic [31:0]       data_new_c;
   logic [3:0]        be_new_c;
   logic [OCC_W-1:0]  occ_c;
   logic              pop_c, slot_free_c, keep_c, drop_c, load_mem_c, load_push_c, mem_we_c;

   // Beat decode: where the incoming pixel lands and whether it closes a word or the frame.
   always_comb begin
      start_c     = (state == S_IDLE) && data_valid && startofpacket && enable;
      acc_c       = start_c || ((state == S_CAPTURE) && data_valid);
      restart_c   = start_c || ((state == S_CAPTURE) && data_valid && startofpacket);
      idx_c       = restart_c ? '0 : pix_cnt;
      wrd_c       = restart_c ? '0 : word_idx;
      lane_c      = idx_c[1:0];
      cnt_new_c   = idx_c + CNT_W'(1);
      data_new_c  = (lane_c == 2'd0) ? 32'd0 : pack_data;
      be_new_c    = (lane_c == 2'd0) ? 4'd0 : pack_be;
      data_new_c[{lane_c, 3'b000} +: 8] = data_in;
      be_new_c[lane_c] = 1'b1;
      last_c      = acc_c && (endofpacket || (cnt_new_c == CNT_W'(N)));
      len_bad_c   = endofpacket != (cnt_new_c == CNT_W'(N));
      word_full_c = acc_c && ((lane_c == 2'd3) || last_c);
      err_set_c   = ((state == S_CAPTURE) && data_valid && startofpacket) || (last_c && len_bad_c);
   end

   // FIFO control: head slot refills from memory first, else straight from the push stage.
   always_comb begin
      occ_c       = mem_cnt + OCC_W'(avm.avm_write);
      pop_c       = avm.avm_write && !avm.avm_waitrequest;
      slot_free_c = !avm.avm_write || pop_c;
      keep_c      = push_vld && (occ_c != OCC_W'(FIFO_DEPTH));
      drop_c      = push_vld && (occ_c == OCC_W'(FIFO_DEPTH));
      load_mem_c  = slot_free_c && (mem_cnt != '0);
      load_push_c = slot_free_c && (mem_cnt == '0) && keep_c;
      mem_we_c    = keep_c && !load_push_c;
   end

   // Frame FSM, packer, push stage and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         pix_cnt     <= '0;
         word_idx    <= '0;
         pack_data   <= '0;
         pack_be     <= '0;
         push_vld    <= 1'b0;
         push_ent    <= '0;
         wbase       <= '0;
         frm_err     <= 1'b0;
         frm_ovf     <= 1'b0;
         frame_done  <= 1'b0;
         cur_buf     <= 1'b0;
         overflow    <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         push_vld   <= 1'b0;
         if (acc_c) begin
            pix_cnt <= cnt_new_c;
            if (word_full_c) begin
               push_vld      <= 1'b1;
               push_ent.off  <= ADDR_W'({wrd_c, 2'b00});
               push_ent.be   <= be_new_c;
               push_ent.data <= data_new_c;
               word_idx      <= wrd_c + CNT_W'(1);
               pack_data     <= '0;
               pack_be       <= '0;
            end else begin
               word_idx  <= wrd_c;
               pack_data <= data_new_c;
               pack_be   <= be_new_c;
            end
         end
         if (err_set_c) frame_error <= 1'b1;
         else if (clear_status) frame_error <= 1'b0;
         if (drop_c) overflow <= 1'b1;
         else if (clear_status) overflow <= 1'b0;
         if (start_c) begin
            frm_err <= err_set_c;
            frm_ovf <= 1'b0;
         end else begin
            frm_err <= frm_err | err_set_c;
            frm_ovf <= frm_ovf | drop_c;
         end
         case (state)
            S_IDLE: begin
               if (start_c) begin
                  state <= last_c ? S_FLUSH : S_CAPTURE;
                  wbase <= cur_buf ? base_addr0 : base_addr1;
               end
            end
            S_CAPTURE: begin
               if (last_c) state <= S_FLUSH;
            end
            S_FLUSH: begin
               if (!push_vld && !avm.avm_write && (mem_cnt == '0)) begin
                  state      <= S_DONE;
                  frame_done <= 1'b1;
                  if (!frm_err && !frm_ovf) cur_buf <= ~cur_buf;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Head slot (the registered Avalon outputs) and FIFO pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         avm.avm_write      <= 1'b0;
         avm.avm_address    <= '0;
         avm.avm_writedata  <= '0;
         avm.avm_byteenable <= '0;
         wr_ptr             <= '0;
         rd_ptr             <= '0;
         mem_cnt            <= '0;
      end else begin
         if (load_mem_c) begin
            avm.avm_write      <= 1'b1;
            avm.avm_address    <= wbase + mem[rd_ptr].off;
            avm.avm_writedata  <= mem[rd_ptr].data;
            avm.avm_byteenable <= mem[rd_ptr].be;
            rd_ptr             <= rd_ptr + PTR_W'(1);
         end else if (load_push_c) begin
            avm.avm_write      <= 1'b1;
            avm.avm_address    <= wbase + push_ent.off;
            avm.avm_writedata  <= push_ent.data;
            avm.avm_byteenable <= push_ent.be;
         end else if (pop_c) begin
            avm.avm_write <= 1'b0;
         end
         if (mem_we_c) wr_ptr <= wr_ptr + PTR_W'(1);
         mem_cnt <= mem_cnt + OCC_W'(mem_we_c) - OCC_W'(load_mem_c);
      end
   end

   // Word storage behind the head slot.
   always_ff @(posedge clk) begin
      if (mem_we_c) mem[wr_ptr] <= push_ent;
   end
endmodule

// File: tb/tb_d5m_frame_writer.sv
// Directed bench for d5m_frame_writer: a frame-level model builds the expected
// Avalon write list, and one monitor checks every accepted write against it.
module tb_d5m_frame_writer;
   localparam int unsigned COLS  = 8;
   localparam int unsigned LINES = 2;
   localparam int unsigned N     = COLS * LINES;
   localparam logic [31:0] BASE0 = 32'h0000_8000;
   localparam logic [31:0] BASE1 = 32'h0000_1000;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n, enable, clear_status, data_valid, sop, eop, sel, wreq;
   logic [7:0] data_in;
   logic       done_a, cur_a, ovf_a, err_a, done_b, cur_b, ovf_b, err_b;
   int         vectors = 0;
   int         miscompares = 0;
   int         done_cnt = 0;
   int         stall_mode = 0;
   int         stall_cnt = 0;
   bit         exp_err;
   exp_t       expq[$];
   logic [7:0] b_data[$];
   bit         b_sop[$];
   bit         b_eop[$];
   logic        prev_w = 1'b0, prev_wait = 1'b0;
   logic [31:0] prev_addr = '0, prev_data = '0;
   logic [3:0]  prev_be = '0;

   always #5 clk = ~clk;

   d5m_frame_writer_if #(.ADDR_W(32)) ifa ();
   d5m_frame_writer_if #(.ADDR_W(32)) ifb ();
   assign ifa.avm_waitrequest = wreq;
   assign ifb.avm_waitrequest = wreq;

   d5m_frame_writer #(.COLS(COLS), .LINES(LINES), .FIFO_DEPTH(16), .ADDR_W(32)) u_a (
      .clk(clk), .rst_n(rst_n), .enable(enable), .clear_status(clear_status),
      .base_addr0(BASE0), .base_addr1(BASE1), .data_in(data_in),
      .data_valid(data_valid & ~sel), .startofpacket(sop), .endofpacket(eop),
      .avm(ifa), .frame_done(done_a), .cur_buf(cur_a), .overflow(ovf_a), .frame_error(err_a));

   d5m_frame_writer #(.COLS(COLS), .LINES(LINES), .FIFO_DEPTH(2), .ADDR_W(32)) u_b (
      .clk(clk), .rst_n(rst_n), .enable(enable), .clear_status(clear_status),
      .base_addr0(BASE0), .base_addr1(BASE1), .data_in(data_in),
      .data_valid(data_valid & sel), .startofpacket(sop), .endofpacket(eop),
      .avm(ifb), .frame_done(done_b), .cur_buf(cur_b), .overflow(ovf_b), .frame_error(err_b));

   wire        mw      = sel ? ifb.avm_write : ifa.avm_write;
   wire        other_w = sel ? ifa.avm_write : ifb.avm_write;
   wire [31:0] maddr   = sel ? ifb.avm_address : ifa.avm_address;
   wire [31:0] mdata   = sel ? ifb.avm_writedata : ifa.avm_writedata;
   wire [3:0]  mbe     = sel ? ifb.avm_byteenable : ifa.avm_byteenable;
   wire        mdone   = sel ? done_b : done_a;
   wire        mcur    = sel ? cur_b : cur_a;
   wire        movf    = sel ? ovf_b : ovf_a;
   wire        merr    = sel ? err_b : err_a;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Frame-level model: slices the beat list into little-endian words at base.
   task automatic model_frame(input logic [31:0] base);
      int          idx;
      logic [31:0] w;
      logic [3:0]  be;
      bit          fin;
      exp_t        e;
      idx = 0; w = '0; be = '0; fin = 1'b0; exp_err = 1'b0;
      for (int i = 0; i < b_data.size(); i++) begin
         if (!fin) begin
            if (b_sop[i]) begin
               if (i != 0) exp_err = 1'b1;
               idx = 0; w = '0; be = '0;
            end
            w[(idx % 4) * 8 +: 8] = b_data[i];
            be[idx % 4] = 1'b1;
            idx++;
            if (b_eop[i] || idx == int'(N)) begin
               if (!(b_eop[i] && idx == int'(N))) exp_err = 1'b1;
               fin = 1'b1;
            end
            if ((idx % 4) == 0 || fin) begin
               e.addr = base + 32'((idx - 1) / 4 * 4);
               e.data = w;
               e.be   = be;
               expq.push_back(e);
               w = '0; be = '0;
            end
         end
      end
   endtask

   task automatic clear_beats();
      b_data.delete(); b_sop.delete(); b_eop.delete();
   endtask

   task automatic add_beats(input logic [7:0] first, input int n, input bit with_eop);
      for (int i = 0; i < n; i++) begin
         b_data.push_back(first + 8'(i));
         b_sop.push_back(i == 0);
         b_eop.push_back(with_eop && (i == n - 1));
      end
   endtask

   task automatic send_stream();
      for (int i = 0; i < b_data.size(); i++) begin
         @(posedge clk); #1;
         data_valid = 1'b1; data_in = b_data[i]; sop = b_sop[i]; eop = b_eop[i];
      end
      @(posedge clk); #1;
      data_valid = 1'b0; sop = 1'b0; eop = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int start_cnt);
      int k;
      k = 0;
      while (done_cnt == start_cnt && k < 600) begin
         @(posedge clk);
         k++;
      end
      if (done_cnt == start_cnt) begin
         vectors++;
         miscompares++;
         $display("FAIL frame_done_timeout: no pulse within %0d cycles", k);
      end
      tick(4);
   endtask

   // Sends the prepared beats and waits for the frame to drain.
   task automatic play_frame();
      int start;
      start = done_cnt;
      send_stream();
      wait_done(start);
      chk("done_once", 72'(done_cnt), 72'(start + 1));
      chk("queue_drained", 72'(expq.size()), 72'(0));
   endtask

   task automatic pulse_clear();
      clear_status = 1'b1;
      tick(1);
      clear_status = 1'b0;
      tick(1);
   endtask

   // Slave stall generator: 1 = stall each write 10 cycles, 2 = stall forever.
   initial forever begin
      @(posedge clk); #1;
      case (stall_mode)
         1: begin
            if (mw && stall_cnt < 10) begin wreq = 1'b1; stall_cnt++; end
            else begin wreq = 1'b0; stall_cnt = 0; end
         end
         2: wreq = 1'b1;
         default: wreq = 1'b0;
      endcase
   end

   // Monitor: stall stability, accepted writes vs. model, quiet inactive DUT.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (mw && prev_w && prev_wait)
         chk("stall_hold", 72'({maddr, mdata, mbe}), 72'({prev_addr, prev_data, prev_be}));
      if (mw && !wreq) begin
         if (expq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write required", maddr, mdata);
         end else begin
            e = expq.pop_front();
            chk("wr_addr", 72'(maddr), 72'(e.addr));
            chk("wr_data", 72'(mdata), 72'(e.data));
            chk("wr_be", 72'(mbe), 72'(e.be));
         end
      end
      chk("idle_quiet", 72'(other_w), 72'(0));
      if (mdone) done_cnt++;
      prev_w = mw; prev_wait = wreq;
      prev_addr = maddr; prev_data = mdata; prev_be = mbe;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; enable = 1'b1; clear_status = 1'b0; data_in = '0;
      data_valid = 1'b0; sop = 1'b0; eop = 1'b0; sel = 1'b0; wreq = 1'b0;
      tick(3);
      chk("rst_write_a", 72'(ifa.avm_write), 72'(0));
      chk("rst_write_b", 72'(ifb.avm_write), 72'(0));
      chk("rst_cur_buf", 72'(cur_a), 72'(0));
      chk("rst_flags", 72'({done_a, ovf_a, err_a}), 72'(0));
      rst_n = 1'b1;
      tick(2);

      // 1: clean frame into buffer 1
      clear_beats(); add_beats(8'h00, 16, 1'b1);
      model_frame(BASE1);
      chk("pin_t1_w0", 72'(expq[0].data), 72'(32'h0302_0100));
      chk("pin_t1_w3", 72'({expq[3].addr, expq[3].data, expq[3].be}), 72'({32'h100C, 32'h0F0E_0D0C, 4'hF}));
      play_frame();
      chk("t1_cur_buf", 72'(mcur), 72'(1));
      chk("t1_flags", 72'({movf, merr}), 72'(0));

      // 2: same stream, every write stalled; buffer 0 now
      stall_mode = 1;
      model_frame(BASE0);
      play_frame();
      stall_mode = 0;
      chk("t2_overflow", 72'(movf), 72'(0));
      chk("t2_cur_buf", 72'(mcur), 72'(0));

      // 3: short frame, eop on beat 14
      clear_beats(); add_beats(8'h00, 14, 1'b1);
      model_frame(BASE1);
      chk("pin_t3_last", 72'({expq[3].addr, expq[3].data, expq[3].be}), 72'({32'h100C, 32'h0000_0D0C, 4'h3}));
      chk("pin_t3_err", 72'(exp_err), 72'(1));
      play_frame();
      chk("t3_frame_error", 72'(merr), 72'(exp_err));
      chk("t3_cur_buf", 72'(mcur), 72'(0));
      pulse_clear();
      chk("t3_cleared", 72'(merr), 72'(0));

      // 4: 2-deep FIFO with the slave stalled for the whole frame
      sel = 1'b1;
      tick(2);
      clear_beats(); add_beats(8'h00, 16, 1'b1);
      model_frame(BASE1);
      void'(expq.pop_back());
      void'(expq.pop_back());
      stall_mode = 2;
      send_stream();
      tick(4);
      chk("t4_overflow", 72'(movf), 72'(1));
      stall_mode = 0;
      wait_done(done_cnt - 1 + 1);
      chk("t4_queue_drained", 72'(expq.size()), 72'(0));
      chk("t4_cur_buf", 72'(mcur), 72'(0));
      chk("t4_frame_error", 72'(merr), 72'(0));
      pulse_clear();
      chk("t4_cleared", 72'(movf), 72'(0));
      sel = 1'b0;
      tick(2);

      // 5: sop reasserted at beat 6, then 16 clean beats
      clear_beats(); add_beats(8'h00, 6, 1'b0); add_beats(8'h10, 16, 1'b1);
      model_frame(BASE1);
      chk("pin_t5_count", 72'(expq.size()), 72'(5));
      chk("pin_t5_w1", 72'({expq[1].addr, expq[1].data}), 72'({32'h1000, 32'h1312_1110}));
      play_frame();
      chk("t5_frame_error", 72'(merr), 72'(1));
      chk("t5_cur_buf", 72'(mcur), 72'(0));
      pulse_clear();

      // 6: reset mid-frame while a write is pending
      stall_mode = 2;
      clear_beats(); add_beats(8'h40, 8, 1'b0);
      send_stream();
      tick(2);
      chk("t6_write_pending", 72'(ifa.avm_write), 72'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_drop", 72'(ifa.avm_write), 72'(0));
      stall_mode = 0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
      clear_beats(); add_beats(8'h20, 16, 1'b1);
      model_frame(BASE1);
      play_frame();
      chk("t6_cur_buf", 72'(mcur), 72'(1));
      chk("t6_frame_error", 72'(merr), 72'(0));

      tick(5);
      chk("final_queue_empty", 72'(expq.size()), 72'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/d5m_frame_writer.md
Name: d5m_frame_writer

Overview:
Downstream of the D5M capture controller. Consumes its 8-bit pixel stream (data_valid / startofpacket / endofpacket).
Packs 4 pixels per 32-bit word, buffers the words in a small FIFO, and writes each frame to SDRAM through an Avalon-MM write master.
Uses ping-pong frame buffers so the display side always reads the last clean frame.

Parameters:
COLS, 800, pixels per line
LINES, 480, lines per frame; frame size N = COLS*LINES pixels
FIFO_DEPTH, 16, entries in the word FIFO (power of 2)
ADDR_W, 32, Avalon-MM address width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
enable  in  1  allow new frames to start
clear_status  in  1  clears the sticky flags (1-cycle pulse)
base_addr0  in  ADDR_W  byte address of buffer 0
base_addr1  in  ADDR_W  byte address of buffer 1
data_in  in  8  pixel byte
data_valid  in  1  pixel beat qualifier
startofpacket  in  1  first pixel of frame (qualified by data_valid)
endofpacket  in  1  last pixel of frame (qualified by data_valid)
avm_address  out  ADDR_W  write byte address
avm_write  out  1  write request
avm_writedata  out  32  write data
avm_byteenable  out  4  byte lanes
avm_waitrequest  in  1  slave stall
frame_done  out  1  1-cycle pulse when a frame has fully drained
cur_buf  out  1  buffer holding the last clean frame
overflow  out  1  sticky: a word was dropped because the FIFO was full
frame_error  out  1  sticky: frame length was wrong

Behaviour:
- Reset (rst_n=0, async): state=IDLE; all outputs 0; cur_buf=0; FIFO empty; packer cleared.
- The write buffer is always !cur_buf.
- Beat: data_valid=1. All beats are ignored in IDLE unless startofpacket=1.
- States:
  - IDLE: on a beat with sop=1 and enable=1, go to CAPTURE. That beat is pixel 0.
  - CAPTURE: accept beats.
  - FLUSH: wait until the FIFO is empty and no write is pending.
  - DONE: one cycle, then IDLE.
- Packing:
  - Little-endian: pixel k occupies byte lane k mod 4.
  - On the 4th byte, the word is pushed the next cycle.
  - FIFO entry = {offset, be[3:0], data[31:0]}, with offset = word_index*4 relative to the write buffer base, computed on the pack side.
- Frame end: a beat with eop=1, or pixel count reaching N.
  - Any partial word is pushed with byteenable covering only the filled lanes; unused data lanes are 0.
  - State goes to FLUSH.
- Error cases:
  - eop when count != N: set frame_error.
  - count reaches N without eop: set frame_error; further beats are ignored until IDLE.
  - sop beat during CAPTURE: set frame_error. Packer, pixel count and word_index restart at 0, and this beat becomes pixel 0. Entries already in the FIFO keep their stored offsets.
- FIFO full when a push is due: the word is dropped and overflow is set. Counting continues, so later addresses stay correct.
- Avalon-MM master:
  - avm_write=1 while the FIFO is non-empty.
  - avm_address = write-buffer base + head offset (base sampled at sop).
  - Address, data and byteenable are registered and held stable while waitrequest=1.
  - Pop on write & !waitrequest.
  - Back-to-back writes are allowed.
- Latency: 4th byte beat at cycle T → avm_write=1 at T+2 at the earliest (empty FIFO, no stall).
- DONE:
  - frame_done pulses.
  - cur_buf toggles only if no frame_error or overflow was raised during this frame (per-frame flags). Otherwise cur_buf is kept.
- enable=0 mid-frame: the current frame completes normally; no new frame starts.
- Sticky flags:
  - clear_status clears overflow and frame_error.
  - If clear_status and a set event occur in the same cycle, set wins.
- Simultaneous sop+eop in IDLE: a 1-pixel frame. Go to FLUSH with frame_error set (unless N=1).
- Reset mid-frame: everything is discarded immediately; avm_write drops to 0 asynchronously.

Test Plan:
1. COLS=8, LINES=2, base1=0x1000, no stall; 16 beats with bytes 0x00..0x0F, sop on first, eop on last → 4 writes to 0x1000/04/08/0C: 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; be=0xF; frame_done pulses once; cur_buf 0→1.
2. Same stream with avm_waitrequest=1 for 10 cycles on every write → address and data stable during each stall; all 4 words correct; no overflow.
3. eop on beat 14 (bytes 0x00..0x0D) → last write to 0x100C with data 0x00000D0C and be=0x3; frame_error=1; cur_buf unchanged.
4. FIFO_DEPTH=2 with waitrequest held high for the whole frame → overflow=1; after release, 2 words are written; cur_buf unchanged; clear_status → overflow=0.
5. sop reasserted at beat 6, then 16 clean beats → frame_error=1; the final 4 words overwrite base offsets 0x0..0xC with the new data.
6. rst_n pulsed low mid-frame while avm_write=1 → avm_write=0 immediately; the next clean frame writes correctly to buffer 1.
